rf_sequencer: RTL and testbench

//  Initiator for the 8 x 16-bit register file (reg16_8 write side, mux8_16 read side).

---
 rtl/rf_seq_pkg.sv | 40 ++++
 rtl/rf_seq_if.sv | 47 ++++
 rtl/rf_seq_alu.sv | 55 +++++
 rtl/rf_sequencer.sv | 161 ++++++++++++++++
 tb/tb_rf_sequencer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/rf_seq_pkg.sv
// rf_seq_pkg: shared constants, enums and helpers for the register-file
// sequencer (rf_sequencer, rf_seq_alu, rf_seq_if).
//   DATA_W   : register/data width (matches the register file)
//   NUM_REGS : register count, also the width of the one-hot load strobe
//   SEL_W    : register index width
//   op_e     : command opcodes
//   state_e  : sequencer FSM states
//   onehot() : register index -> one-hot load strobe
package rf_seq_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int SEL_W    = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MOV = 3'd5,
    OP_LDI = 3'd6,
    OP_NOP = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_B  = 3'd2,
    EXEC  = 3'd3,
    WRITE = 3'd4
  } state_e;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_REGS-1:0] one;
    one = {{(NUM_REGS-1){1'b0}}, 1'b1};
    return one << sel;
  endfunction

endpackage

// File: rtl/rf_seq_if.sv
// rf_seq_if: bundles the command handshake and the register-file access
// signals of the sequencer.
//   master modport : the environment side (front end issuing commands plus
//                    the register file's read mux / write side)
//   slave modport  : the sequencer
//   Command : cmd_valid, cmd_ready, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm
//   Read    : rd_sel (to read mux), rd_data (combinational read data)
//   Write   : wr_load (one-hot load strobe), wr_data, done (retire pulse)
//   Flags   : flag_z, flag_c, flag_v exist only when RF_SEQ_FLAGS_EN is defined
interface rf_seq_if;
  import rf_seq_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  op_e                 cmd_op;
  logic [SEL_W-1:0]    cmd_rd;
  logic [SEL_W-1:0]    cmd_rs1;
  logic [SEL_W-1:0]    cmd_rs2;
  logic [DATA_W-1:0]   cmd_imm;
  logic [SEL_W-1:0]    rd_sel;
  logic [DATA_W-1:0]   rd_data;
  logic [NUM_REGS-1:0] wr_load;
  logic [DATA_W-1:0]   wr_data;
  logic                done;
`ifdef RF_SEQ_FLAGS_EN
  logic                flag_z;
  logic                flag_c;
  logic                flag_v;
`endif

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rd_data,
    input  cmd_ready, rd_sel, wr_load, wr_data, done
`ifdef RF_SEQ_FLAGS_EN
    , input flag_z, flag_c, flag_v
`endif
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rd_data,
    output cmd_ready, rd_sel, wr_load, wr_data, done
`ifdef RF_SEQ_FLAGS_EN
    , output flag_z, flag_c, flag_v
`endif
  );

endinterface

// File: rtl/rf_seq_alu.sv
// rf_seq_alu: combinational ALU used in the EXEC state of rf_sequencer.
//   op     : opcode (op_e)
//   a, b   : operands read from the register file
//   imm    : immediate (LDI)
//   result : DATA_W-bit result, ADD/SUB wrap modulo 2^DATA_W
//   c, v   : carry/borrow and signed overflow (only with RF_SEQ_FLAGS_EN)
module rf_seq_alu
  import rf_seq_pkg::*;
(
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result
`ifdef RF_SEQ_FLAGS_EN
  ,
  output logic              c,
  output logic              v
`endif
);

  always_comb begin
    result = '0;
`ifdef RF_SEQ_FLAGS_EN
    c = 1'b0;
    v = 1'b0;
`endif
    case (op)
      OP_ADD: begin
`ifdef RF_SEQ_FLAGS_EN
        {c, result} = {1'b0, a} + {1'b0, b};
        v = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
`else
        result = a + b;
`endif
      end
      OP_SUB: begin
`ifdef RF_SEQ_FLAGS_EN
        // Extended subtract: the top bit is the borrow, set exactly when a < b.
        {c, result} = {1'b0, a} - {1'b0, b};
        v = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
`else
        result = a - b;
`endif
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_MOV:  result = a;
      OP_LDI:  result = imm;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rf_sequencer.sv
// rf_sequencer: initiator for the 8 x 16-bit register file. Accepts one ALU
// command over a valid/ready handshake, reads operands through the single
// read port, computes the result and writes it back with a one-hot strobe.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : rf_seq_if.slave (command handshake, read port, write port, done,
//           and flag_z/flag_c/flag_v when RF_SEQ_FLAGS_EN is defined)
// Optional feature macro: RF_SEQ_FLAGS_EN (adds Z/C/V flag outputs).
module rf_sequencer
  import rf_seq_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  rf_seq_if.slave  bus
);

  state_e              state_reg, state_next;
  op_e                 op_reg;
  logic [SEL_W-1:0]    rd_reg, rs1_reg, rs2_reg;
  logic [DATA_W-1:0]   imm_reg;
  logic [DATA_W-1:0]   opa_reg, opb_reg, result_reg;
  logic [SEL_W-1:0]    rd_sel_reg, rd_sel_next;
  logic [NUM_REGS-1:0] wr_load_c;
  logic [DATA_W-1:0]   wr_data_c;
  logic                done_c;
  logic                accept;
  logic [DATA_W-1:0]   alu_result;

  // Ready is forced low while reset is held so nothing is accepted then.
  assign bus.cmd_ready = (state_reg == IDLE) && reset;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: the path through the FSM depends on the opcode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_LDI:  state_next = EXEC;
            OP_NOP:  state_next = WRITE;
            default: state_next = RD_A;
          endcase
        end
      end
      RD_A:    state_next = (op_reg == OP_MOV) ? EXEC : RD_B;
      RD_B:    state_next = EXEC;
      EXEC:    state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic. rd_sel is prepared one state ahead so the registered
  // select is stable for the whole RD_A / RD_B cycle; RD_A is only entered
  // from the accept cycle, so rs1 comes straight from the command inputs.
  always_comb begin
    rd_sel_next = '0;
    case (state_next)
      RD_A:    rd_sel_next = bus.cmd_rs1;
      RD_B:    rd_sel_next = rs2_reg;
      default: rd_sel_next = '0;
    endcase

    wr_load_c = '0;
    wr_data_c = '0;
    done_c    = 1'b0;
    if (state_reg == WRITE) begin
      wr_load_c = (op_reg == OP_NOP) ? '0 : onehot(rd_reg);
      wr_data_c = result_reg;
      done_c    = 1'b1;
    end
  end

  assign bus.rd_sel  = rd_sel_reg;
  assign bus.wr_load = wr_load_c;
  assign bus.wr_data = wr_data_c;
  assign bus.done    = done_c;

`ifdef RF_SEQ_FLAGS_EN
  logic alu_c, alu_v;
  logic c_reg, v_reg;
  logic flag_z_reg, flag_c_reg, flag_v_reg;
`endif

  rf_seq_alu u_alu (
    .op     (op_reg),
    .a      (opa_reg),
    .b      (opb_reg),
    .imm    (imm_reg),
    .result (alu_result)
`ifdef RF_SEQ_FLAGS_EN
    ,
    .c      (alu_c),
    .v      (alu_v)
`endif
  );

  // Command latch, operand capture and result register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_reg     <= OP_ADD;
      rd_reg     <= '0;
      rs1_reg    <= '0;
      rs2_reg    <= '0;
      imm_reg    <= '0;
      opa_reg    <= '0;
      opb_reg    <= '0;
      result_reg <= '0;
      rd_sel_reg <= '0;
    end else begin
      if (accept) begin
        op_reg  <= bus.cmd_op;
        rd_reg  <= bus.cmd_rd;
        rs1_reg <= bus.cmd_rs1;
        rs2_reg <= bus.cmd_rs2;
        imm_reg <= bus.cmd_imm;
      end
      // Read data is captured on the edge that leaves each read state.
      if (state_reg == RD_A) opa_reg <= bus.rd_data;
      if (state_reg == RD_B) opb_reg <= bus.rd_data;
      if (state_reg == EXEC) result_reg <= alu_result;
      rd_sel_reg <= rd_sel_next;
    end
  end

`ifdef RF_SEQ_FLAGS_EN
  // Carry/overflow are held from EXEC and committed together with Z at the
  // end of WRITE, so flags change at the same edge as the register file.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_reg      <= 1'b0;
      v_reg      <= 1'b0;
      flag_z_reg <= 1'b0;
      flag_c_reg <= 1'b0;
      flag_v_reg <= 1'b0;
    end else begin
      if (state_reg == EXEC) begin
        c_reg <= alu_c;
        v_reg <= alu_v;
      end
      if ((state_reg == WRITE) && (op_reg <= OP_XOR)) begin
        flag_z_reg <= (result_reg == '0);
        flag_c_reg <= c_reg;
        flag_v_reg <= v_reg;
      end
    end
  end

  assign bus.flag_z = flag_z_reg;
  assign bus.flag_c = flag_c_reg;
  assign bus.flag_v = flag_v_reg;
`endif

endmodule

// File: tb/tb_rf_sequencer.sv
// tb_rf_sequencer: scoreboard bench for rf_sequencer wrapped with a simple
// 8 x 16 register file (load strobes on write, combinational read mux).
// Stimulus pushes the expected write-back into a queue; a monitor pops and
// compares whenever done is seen.
module tb_rf_sequencer;
  import rf_seq_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rf_clr = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  rf_seq_if bus ();

  rf_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file model
  logic [15:0] regs [8];
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (rf_clr) regs[i] <= 16'h0;
      else if (bus.wr_load[i]) regs[i] <= bus.wr_data;
    end
  end
  assign bus.rd_data = regs[bus.rd_sel];

  typedef struct {
    string       name;
    logic [7:0]  load;
    logic [15:0] data;
    bit          chk_data;
    int          lat;
    bit          chk_flags;
    logic [2:0]  flags;   // {z, c, v}
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];

  function automatic exp_t mk(input string name, input logic [7:0] load, input logic [15:0] data,
                              input bit chk_data, input int lat, input bit chk_flags, input logic [2:0] flags);
    exp_t e;
    e.name = name; e.load = load; e.data = data; e.chk_data = chk_data;
    e.lat = lat; e.chk_flags = chk_flags; e.flags = flags;
    return e;
  endfunction

  // Record the cycle of every accepted command.
  always @(posedge clk) begin
    if (bus.cmd_valid && bus.cmd_ready) acc_q.push_back(cyc);
  end

  // Monitor / scoreboard
  bit         flag_pend = 1'b0;
  logic [2:0] flag_exp = 3'b000;
  string      flag_name = "";
  always begin
    @(posedge clk);
    #2;
    checks++;
    if (bus.wr_load != 8'h0 && (!bus.done || $countones(bus.wr_load) != 1)) begin
      errors++;
      $display("FAIL wr_load_invariant: got wr_load=%b done=%b, require one-hot only with done", bus.wr_load, bus.done);
    end
`ifdef RF_SEQ_FLAGS_EN
    if (flag_pend) begin
      flag_pend = 1'b0;
      checks++;
      if ({bus.flag_z, bus.flag_c, bus.flag_v} !== flag_exp) begin
        errors++;
        $display("FAIL %s_flags: got zcv=%b want %b", flag_name, {bus.flag_z, bus.flag_c, bus.flag_v}, flag_exp);
      end
    end
`endif
    if (bus.done) begin
      checks++;
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=1 want no pending command");
      end else begin
        exp_t e;
        int   a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        $display("txn %s: wr_load=%b wr_data=%h latency=%0d", e.name, bus.wr_load, bus.wr_data, cyc - a);
        if (bus.wr_load !== e.load) begin
          errors++;
          $display("FAIL %s_load: got %b want %b", e.name, bus.wr_load, e.load);
        end
        checks++;
        if (cyc - a != e.lat) begin
          errors++;
          $display("FAIL %s_latency: got %0d want %0d", e.name, cyc - a, e.lat);
        end
        if (e.chk_data) begin
          checks++;
          if (bus.wr_data !== e.data) begin
            errors++;
            $display("FAIL %s_data: got %h want %h", e.name, bus.wr_data, e.data);
          end
        end
        if (e.chk_flags) begin
          flag_pend = 1'b1;
          flag_exp  = e.flags;
          flag_name = e.name;
        end
      end
    end
  end

  task automatic send(input op_e op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                      input logic [15:0] imm, input bit hold, input exp_t e);
    int n;
    @(negedge clk);
    bus.cmd_op    = op;
    bus.cmd_rd    = rd;
    bus.cmd_rs1   = rs1;
    bus.cmd_rs2   = rs2;
    bus.cmd_imm   = imm;
    bus.cmd_valid = 1'b1;
    exp_q.push_back(e);
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!bus.cmd_ready && n < 50);
    if (n >= 50) begin
      errors++;
      checks++;
      $display("FAIL %s_accept_timeout: got no accept in 50 cycles want accept", e.name);
    end
    if (!hold) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end else begin
      $display("chk %s: %h", name, got);
    end
  endtask

  logic [15:0] exp_regs [8];

  initial begin
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_rd    = '0;
    bus.cmd_rs1   = '0;
    bus.cmd_rs2   = '0;
    bus.cmd_imm   = '0;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'h0);
    rf_clr = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    chk("idle_rd_sel",    32'(bus.rd_sel),    32'h0);
    chk("idle_wr_load",   32'(bus.wr_load),   32'h0);
    chk("idle_wr_data",   32'(bus.wr_data),   32'h0);
    chk("idle_done",      32'(bus.done),      32'h0);

    // 1. LDI
    send(OP_LDI, 3, 0, 0, 16'h1234, 0, mk("ldi_r3", 8'h08, 16'h1234, 1, 2, 1, 3'b000));
    // 2. ADD with wrap and carry
    send(OP_LDI, 1, 0, 0, 16'hFFFF, 0, mk("ldi_r1", 8'h02, 16'hFFFF, 1, 2, 0, 3'b000));
    send(OP_LDI, 2, 0, 0, 16'h0001, 0, mk("ldi_r2", 8'h04, 16'h0001, 1, 2, 0, 3'b000));
    send(OP_ADD, 4, 1, 2, 16'h0,    0, mk("add_r4", 8'h10, 16'h0000, 1, 4, 1, 3'b110));
    // 3. SUB with signed overflow, rd==rs1, then MOV
    send(OP_LDI, 1, 0, 0, 16'h8000, 0, mk("ldi_r1b", 8'h02, 16'h8000, 1, 2, 0, 3'b000));
    send(OP_SUB, 1, 1, 2, 16'h0,    0, mk("sub_r1", 8'h02, 16'h7FFF, 1, 4, 1, 3'b001));
    send(OP_MOV, 5, 1, 0, 16'h0,    0, mk("mov_r5", 8'h20, 16'h7FFF, 1, 3, 1, 3'b001));
    // 4. valid held high across three back-to-back commands with dependencies
    send(OP_LDI, 6, 0, 0, 16'h00F0, 1, mk("ldi_r6", 8'h40, 16'h00F0, 1, 2, 1, 3'b001));
    send(OP_ADD, 7, 6, 6, 16'h0,    1, mk("add_r7", 8'h80, 16'h01E0, 1, 4, 1, 3'b000));
    send(OP_XOR, 0, 7, 6, 16'h0,    0, mk("xor_r0", 8'h01, 16'h0110, 1, 4, 1, 3'b000));
    // 5. reset during RD_B of an XOR aborts it
    send(OP_XOR, 3, 1, 2, 16'h0,    0, mk("xor_abort", 8'h08, 16'h0, 0, 4, 0, 3'b000));
    @(negedge clk);   // RD_B cycle
    reset = 1'b0;
    #1;
    void'(exp_q.pop_back());
    if (acc_q.size() > 0) void'(acc_q.pop_back());
    chk("abort_cmd_ready", 32'(bus.cmd_ready), 32'h0);
    chk("abort_rd_sel",    32'(bus.rd_sel),    32'h0);
    chk("abort_wr_load",   32'(bus.wr_load),   32'h0);
    chk("abort_wr_data",   32'(bus.wr_data),   32'h0);
    chk("abort_done",      32'(bus.done),      32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_r3_kept", 32'(regs[3]), 32'h1234);
    send(OP_LDI, 3, 0, 0, 16'hBEEF, 0, mk("ldi_r3b", 8'h08, 16'hBEEF, 1, 2, 1, 3'b000));
    // 6. ADD setting V, then NOP leaves registers and flags alone
    send(OP_ADD, 4, 1, 2, 16'h0,    0, mk("add_r4b", 8'h10, 16'h8000, 1, 4, 1, 3'b001));
    send(OP_NOP, 2, 1, 1, 16'hAAAA, 0, mk("nop", 8'h00, 16'h0, 0, 1, 1, 3'b001));

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
    end
    repeat (3) @(negedge clk);

    exp_regs[0] = 16'h0110; exp_regs[1] = 16'h7FFF; exp_regs[2] = 16'h0001; exp_regs[3] = 16'hBEEF;
    exp_regs[4] = 16'h8000; exp_regs[5] = 16'h7FFF; exp_regs[6] = 16'h00F0; exp_regs[7] = 16'h01E0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("final_r%0d", i), 32'(regs[i]), 32'(exp_regs[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
